// File: rtl/aurora_link_ctrl_if.sv
// Aurora core control/status bundle: link status inputs from the core and
// the two reset lines driven back to it.
interface aurora_link_ctrl_if;
   logic lane_up;
   logic channel_up;
   logic hard_err;
   logic gt_reset;
   logic core_reset;

   // Controller side: observes core status, drives core resets
   modport master (
      input  lane_up,
      input  channel_up,
      input  hard_err,
      output gt_reset,
      output core_reset
   );

   // Aurora core side
   modport slave (
      output lane_up,
      output channel_up,
      output hard_err,
      input  gt_reset,
      input  core_reset
   );
endinterface

// File: rtl/aurora_link_ctrl.sv
// Aurora 8b10b link bring-up/recovery sequencer on clk156.
// GT reset, then core reset, then wait for lane_up and channel_up under a
// shared timeout; monitor the link with a channel_up drop filter and hard
// error detection; bounded retries ending in FAILED.
module aurora_link_ctrl #(
   parameter int unsigned GT_RST_CYCLES   = 128,
   parameter int unsigned CORE_RST_CYCLES = 67108864,
   parameter int unsigned LINK_TIMEOUT    = 156250000,
   parameter int unsigned DROP_FILTER     = 16,
   parameter int unsigned MAX_RETRIES     = 8
) (
   input  logic                      clk156,
   input  logic                      reset_n,
   input  logic                      restart,
   aurora_link_ctrl_if.master        aur,
   output logic                      link_ok,
   output logic                      link_failed,
   output logic [7:0]                retry_count,
   output logic [2:0]                state
);

   localparam int unsigned DROP_W = (DROP_FILTER > 1) ? $clog2(DROP_FILTER + 1) : 1;

   localparam logic [31:0]       GT_LAST   = 32'(GT_RST_CYCLES - 1);
   localparam logic [31:0]       CORE_LAST = 32'(CORE_RST_CYCLES - 1);
   localparam logic [31:0]       LINK_LAST = 32'(LINK_TIMEOUT - 1);
   localparam logic [DROP_W-1:0] DROP_LAST = DROP_W'(DROP_FILTER - 1);
   localparam logic [7:0]        RETRY_MAX = 8'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_GT_RST    = 3'd0,
      ST_CORE_RST  = 3'd1,
      ST_WAIT_LANE = 3'd2,
      ST_WAIT_CHAN = 3'd3,
      ST_UP        = 3'd4,
      ST_RETRY     = 3'd5,
      ST_FAILED    = 3'd6
   } state_t;

   // Synchroniser bit order: {hard_err, channel_up, lane_up}
   logic [2:0]        sync1_q;
   logic [2:0]        sync2_q;
   logic              lane_up_s;
   logic              channel_up_s;
   logic              hard_err_s;

   state_t            state_q, state_d;
   logic [31:0]       timer_q, timer_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic [7:0]        retry_q, retry_d;
   logic              gt_reset_q, gt_reset_d;
   logic              core_reset_q, core_reset_d;
   logic              link_ok_q, link_ok_d;
   logic              link_failed_q, link_failed_d;

   assign lane_up_s    = sync2_q[0];
   assign channel_up_s = sync2_q[1];
   assign hard_err_s   = sync2_q[2];

   // Two-flop synchronisers for the asynchronous core status inputs
   always_ff @(posedge clk156 or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {aur.hard_err, aur.channel_up, aur.lane_up};
         sync2_q <= sync1_q;
      end
   end

   // Next-state, timer, drop filter and retry bookkeeping
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      drop_d  = '0;
      retry_d = retry_q;

      case (state_q)
         ST_GT_RST: begin
            if (timer_q == GT_LAST) begin
               state_d = ST_CORE_RST;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end

         ST_CORE_RST: begin
            if (timer_q == CORE_LAST) begin
               state_d = ST_WAIT_LANE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end

         // Timer keeps running into WAIT_CHAN: one budget covers both waits
         ST_WAIT_LANE: begin
            if (timer_q == LINK_LAST) begin
               state_d = ST_RETRY;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 32'd1;
               if (lane_up_s) begin
                  state_d = ST_WAIT_CHAN;
               end
            end
         end

         ST_WAIT_CHAN: begin
            if (timer_q == LINK_LAST) begin
               state_d = ST_RETRY;
               timer_d = '0;
            end else if (channel_up_s) begin
               state_d = ST_UP;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end

         // Hard error beats the drop filter; any high sample resets the filter
         ST_UP: begin
            if (hard_err_s) begin
               state_d = ST_RETRY;
            end else if (!channel_up_s) begin
               if (drop_q == DROP_LAST) begin
                  state_d = ST_RETRY;
               end else begin
                  drop_d = drop_q + DROP_W'(1);
               end
            end
         end

         ST_RETRY: begin
            timer_d = '0;
            if ((retry_q < RETRY_MAX) && (retry_q != 8'hFF)) begin
               retry_d = retry_q + 8'd1;
               state_d = ST_GT_RST;
            end else begin
               state_d = ST_FAILED;
            end
         end

         ST_FAILED: begin
            state_d = ST_FAILED;
         end

         default: begin
            state_d = ST_GT_RST;
            timer_d = '0;
         end
      endcase

      if (restart) begin
         state_d = ST_GT_RST;
         timer_d = '0;
         drop_d  = '0;
         retry_d = '0;
      end
   end

   // Output decode from the next state so outputs change on the entering edge
   always_comb begin
      gt_reset_d    = (state_d == ST_GT_RST) || (state_d == ST_RETRY) ||
                      (state_d == ST_FAILED);
      core_reset_d  = (state_d == ST_GT_RST) || (state_d == ST_CORE_RST) ||
                      (state_d == ST_RETRY)  || (state_d == ST_FAILED);
      link_ok_d     = (state_d == ST_UP);
      link_failed_d = (state_d == ST_FAILED);
   end

   // State register with registered outputs
   always_ff @(posedge clk156 or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_GT_RST;
         timer_q       <= '0;
         drop_q        <= '0;
         retry_q       <= '0;
         gt_reset_q    <= 1'b1;
         core_reset_q  <= 1'b1;
         link_ok_q     <= 1'b0;
         link_failed_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         drop_q        <= drop_d;
         retry_q       <= retry_d;
         gt_reset_q    <= gt_reset_d;
         core_reset_q  <= core_reset_d;
         link_ok_q     <= link_ok_d;
         link_failed_q <= link_failed_d;
      end
   end

   assign aur.gt_reset   = gt_reset_q;
   assign aur.core_reset = core_reset_q;
   assign link_ok        = link_ok_q;
   assign link_failed    = link_failed_q;
   assign retry_count    = retry_q;
   assign state          = state_q;

endmodule

// File: tb/tb_aurora_link_ctrl.sv
// Directed bench for aurora_link_ctrl with small timing parameters.
// Cycle numbers count rising edges after reset_n release.
module tb_aurora_link_ctrl;

   logic       clk156;
   logic       reset_n;
   logic       restart;
   logic       link_ok;
   logic       link_failed;
   logic [7:0] retry_count;
   logic [2:0] state;

   int unsigned cyc;
   int unsigned checks;
   int unsigned errors;

   aurora_link_ctrl_if aur_if ();

   aurora_link_ctrl #(
      .GT_RST_CYCLES   (4),
      .CORE_RST_CYCLES (8),
      .LINK_TIMEOUT    (50),
      .DROP_FILTER     (3),
      .MAX_RETRIES     (2)
   ) dut (
      .clk156      (clk156),
      .reset_n     (reset_n),
      .restart     (restart),
      .aur         (aur_if.master),
      .link_ok     (link_ok),
      .link_failed (link_failed),
      .retry_count (retry_count),
      .state       (state)
   );

   initial clk156 = 1'b0;
   always #5 clk156 = ~clk156;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Advance to 1 ns after rising edge n
   task automatic run_to(input int unsigned n);
      while (cyc < n) begin
         @(posedge clk156);
         #1;
         cyc++;
      end
   endtask

   initial begin
      cyc     = 0;
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      restart = 1'b0;
      aur_if.lane_up    = 1'b0;
      aur_if.channel_up = 1'b0;
      aur_if.hard_err   = 1'b0;

      repeat (2) @(posedge clk156);
      #1;
      check_eq("rst_state",   32'(state), 32'd0);
      check_eq("rst_gt",      32'(aur_if.gt_reset), 32'd1);
      check_eq("rst_core",    32'(aur_if.core_reset), 32'd1);
      check_eq("rst_ok",      32'(link_ok), 32'd0);
      check_eq("rst_failed",  32'(link_failed), 32'd0);
      check_eq("rst_retry",   32'(retry_count), 32'd0);
      #3 reset_n = 1'b1;
      cyc = 0;

      // Bring-up: gt_reset 4 cycles, core_reset 12 cycles
      run_to(3);
      check_eq("gt_hold",     32'(aur_if.gt_reset), 32'd1);
      check_eq("gt_hold_st",  32'(state), 32'd0);
      run_to(4);
      check_eq("gt_drop",     32'(aur_if.gt_reset), 32'd0);
      check_eq("core_hold",   32'(aur_if.core_reset), 32'd1);
      check_eq("core_st",     32'(state), 32'd1);
      run_to(11);
      check_eq("core_hold2",  32'(aur_if.core_reset), 32'd1);
      run_to(12);
      check_eq("core_drop",   32'(aur_if.core_reset), 32'd0);
      check_eq("core_drop_gt", 32'(aur_if.gt_reset), 32'd0);
      check_eq("wait_lane",   32'(state), 32'd2);
      run_to(15);
      aur_if.lane_up = 1'b1;
      run_to(17);
      check_eq("lane_sync",   32'(state), 32'd2);
      run_to(18);
      check_eq("wait_chan",   32'(state), 32'd3);
      run_to(20);
      aur_if.channel_up = 1'b1;
      run_to(22);
      check_eq("chan_sync",   32'(state), 32'd3);
      check_eq("chan_sync_ok", 32'(link_ok), 32'd0);
      run_to(23);
      check_eq("up_state",    32'(state), 32'd4);
      check_eq("up_ok",       32'(link_ok), 32'd1);
      check_eq("up_retry",    32'(retry_count), 32'd0);

      // Drop filter: 2-cycle drop ignored
      run_to(25);
      aur_if.channel_up = 1'b0;
      run_to(27);
      aur_if.channel_up = 1'b1;
      run_to(29);
      check_eq("glitch_ok1",  32'(link_ok), 32'd1);
      run_to(32);
      check_eq("glitch_ok2",  32'(link_ok), 32'd1);
      check_eq("glitch_st",   32'(state), 32'd4);

      // Drop filter: 3-cycle drop triggers retry
      aur_if.channel_up = 1'b0;
      run_to(35);
      aur_if.channel_up = 1'b1;
      run_to(36);
      check_eq("drop_ok_pre", 32'(link_ok), 32'd1);
      run_to(37);
      check_eq("drop_retry",  32'(state), 32'd5);
      check_eq("drop_ok",     32'(link_ok), 32'd0);
      check_eq("drop_gt",     32'(aur_if.gt_reset), 32'd1);
      check_eq("drop_core",   32'(aur_if.core_reset), 32'd1);
      run_to(38);
      check_eq("drop_gtrst",  32'(state), 32'd0);
      check_eq("drop_cnt",    32'(retry_count), 32'd1);
      run_to(51);
      check_eq("reup_chan",   32'(state), 32'd3);
      run_to(52);
      check_eq("reup_state",  32'(state), 32'd4);
      check_eq("reup_ok",     32'(link_ok), 32'd1);

      // Hard error pulse while channel_up stays high
      run_to(53);
      aur_if.hard_err = 1'b1;
      run_to(54);
      aur_if.hard_err = 1'b0;
      run_to(55);
      check_eq("herr_sync",   32'(state), 32'd4);
      run_to(56);
      check_eq("herr_retry",  32'(state), 32'd5);
      check_eq("herr_gt",     32'(aur_if.gt_reset), 32'd1);
      run_to(57);
      check_eq("herr_gtrst",  32'(state), 32'd0);
      check_eq("herr_cnt",    32'(retry_count), 32'd2);

      // Restart mid-CORE_RST
      aur_if.lane_up    = 1'b0;
      aur_if.channel_up = 1'b0;
      run_to(62);
      check_eq("core_again",  32'(state), 32'd1);
      run_to(64);
      restart = 1'b1;
      run_to(65);
      restart = 1'b0;
      check_eq("rs_state",    32'(state), 32'd0);
      check_eq("rs_cnt",      32'(retry_count), 32'd0);
      check_eq("rs_gt",       32'(aur_if.gt_reset), 32'd1);
      check_eq("rs_core",     32'(aur_if.core_reset), 32'd1);
      run_to(68);
      check_eq("rs_gt_full",  32'(aur_if.gt_reset), 32'd1);
      run_to(69);
      check_eq("rs_gt_end",   32'(aur_if.gt_reset), 32'd0);
      check_eq("rs_core_st",  32'(state), 32'd1);
      run_to(77);
      check_eq("to1_wait",    32'(state), 32'd2);

      // Timeouts: 1st with lane_up never seen
      run_to(126);
      check_eq("to1_pre",     32'(state), 32'd2);
      run_to(127);
      check_eq("to1_retry",   32'(state), 32'd5);
      run_to(128);
      check_eq("to1_cnt",     32'(retry_count), 32'd1);
      check_eq("to1_gtrst",   32'(state), 32'd0);

      // 2nd timeout: lane_up mid-wait, timer continues into WAIT_CHAN
      run_to(140);
      check_eq("to2_wait",    32'(state), 32'd2);
      run_to(150);
      aur_if.lane_up = 1'b1;
      run_to(153);
      check_eq("to2_chan",    32'(state), 32'd3);
      run_to(189);
      check_eq("to2_pre",     32'(state), 32'd3);
      run_to(190);
      check_eq("to2_retry",   32'(state), 32'd5);
      run_to(191);
      check_eq("to2_cnt",     32'(retry_count), 32'd2);

      // 3rd expiry parks in FAILED
      run_to(204);
      check_eq("to3_chan",    32'(state), 32'd3);
      run_to(253);
      check_eq("to3_retry",   32'(state), 32'd5);
      check_eq("to3_nofail",  32'(link_failed), 32'd0);
      run_to(254);
      check_eq("fail_state",  32'(state), 32'd6);
      check_eq("fail_flag",   32'(link_failed), 32'd1);
      check_eq("fail_cnt",    32'(retry_count), 32'd2);
      check_eq("fail_gt",     32'(aur_if.gt_reset), 32'd1);
      check_eq("fail_core",   32'(aur_if.core_reset), 32'd1);
      check_eq("fail_ok",     32'(link_ok), 32'd0);
      run_to(260);
      check_eq("fail_park",   32'(state), 32'd6);

      // Restart out of FAILED
      restart = 1'b1;
      run_to(261);
      restart = 1'b0;
      check_eq("rf_state",    32'(state), 32'd0);
      check_eq("rf_cnt",      32'(retry_count), 32'd0);
      check_eq("rf_failed",   32'(link_failed), 32'd0);
      check_eq("rf_gt",       32'(aur_if.gt_reset), 32'd1);
      run_to(265);
      aur_if.channel_up = 1'b1;
      run_to(275);
      check_eq("rf_up",       32'(state), 32'd4);
      check_eq("rf_up_ok",    32'(link_ok), 32'd1);

      // Async reset between edges while UP
      run_to(277);
      #3 reset_n = 1'b0;
      #1;
      check_eq("ar_state",    32'(state), 32'd0);
      check_eq("ar_gt",       32'(aur_if.gt_reset), 32'd1);
      check_eq("ar_core",     32'(aur_if.core_reset), 32'd1);
      check_eq("ar_ok",       32'(link_ok), 32'd0);
      #10 reset_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
